fsm_context_scheduler: RTL and testbench
========================================

Name: fsm_context_scheduler

Overview:
Time-multiplexes one shared I/S/T genomics symbol-tracking Moore FSM across NREQ independent bit-stream requesters.
- Each requester keeps its own saved 2-bit FSM context.
- A round-robin arbiter with a burst limit grants the shared next-state/output logic to one requester at a time.
- The block sits between the per-lane symbol sources and the downstream code collector.

Parameters:
NREQ, 4, number of requesters (2..16)
IDW, 2, requester-id width, equals clog2(NREQ)
BURST, 4, maximum symbols consumed per grant (1..15)

Ports:
clk  input  1  system clock, all state updates on its rising edge
reset  input  1  asynchronous, active-high; clears all state
req_valid  input  NREQ  bit i high: requester i presents a symbol
req_bit  input  NREQ  symbol bit of requester i (the FSM "in")
ctx_clear  input  NREQ  single-cycle pulse: force context i to state I
req_ready  output  NREQ  one-hot, combinational; bit i high means requester i's symbol is consumed this cycle
busy  output  1  high while arbiter is in GRANT
out_valid  output  1  registered; one result per consumed symbol
out_id  output  IDW  registered; requester id of the result
out_code  output  2  registered; Moore output of the updated context

Behaviour:
- Context encoding: I=0, S=1, T=2. ctx[i] resets to I.
- Shared next-state function:
  - I -> S (regardless of bit)
  - S -> T if bit else S
  - T -> S if bit else T
  - encoding 3 -> I
- Output code of the new state: I=01, S=10, T=11, 3=00.
- Arbiter states:
  - IDLE: no consumption, req_ready=0.
    - If any req_valid: owner = first valid index at or after ptr, scanning upward modulo NREQ; burst_cnt=0; go to GRANT.
    - Else stay in IDLE.
  - GRANT:
    - If req_valid[owner]=1: req_ready[owner]=1. Next edge: ctx[owner] = next_state, burst_cnt+1, out_valid=1, out_id=owner, out_code=code(new state).
    - If that consumption makes burst_cnt reach BURST: go to IDLE, ptr = (owner+1) mod NREQ.
    - If req_valid[owner]=0: no consumption, go to IDLE, ptr = (owner+1) mod NREQ.
- Latency:
  - Request seen in IDLE -> first consumption 1 cycle later.
  - Consumption -> out_valid on the next rising edge (1 cycle).
- out_valid is low in every cycle following a non-consuming cycle. There is no output backpressure.
- Between consecutive grants there is always exactly one IDLE cycle.
- ctx_clear[i]:
  - Sets ctx[i]=I on the edge.
  - If coincident with consumption by i: the clear wins, ctx[i]=I, the result is still emitted with out_code=01, and the symbol counts toward the burst.
  - Clearing a non-owner context has no effect on arbitration.
- req_bit and req_valid of non-owners are ignored. Unconsumed requests persist; the arbiter never drops them.
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE, ptr=0, burst_cnt=0, all ctx=I.
  - out_valid=0, out_id=0, out_code=00, busy=0.
  - req_ready=0 while reset is high.
- After reset deasserts, the first arbitration occurs on the first edge with req_valid nonzero.

Test Plan:
1. Reset with req_valid=4'b1111 -> req_ready=0, busy=0, out_valid/out_id/out_code=0 while reset held. First edge after release: owner=0.
2. Only req 0 valid, bits 1,1,0,1, BURST=4 -> out_code 10,11,11,10 with out_id=0 on 4 consecutive cycles, then one IDLE cycle, then ptr=1. Req 0 is re-granted after ptr scan wraps.
3. Req 0 and 2 valid continuously -> grant pattern: 4 symbols id0, IDLE, 4 symbols id2, IDLE, id0... Contexts evolve independently (req 2 first code is 10 from I).
4. Req 1 drives bits 1,1 (ctx=T), deasserts valid mid-grant -> release, IDLE. Later req 1 bit 0 -> out_code=11 (T held, context preserved).
5. ctx_clear[3] pulsed on the same cycle req 3 is consumed with bit 1 from S -> out_code=01 and the next symbol from req 3 yields 10.
6. Reset asserted on the 2nd cycle of a burst -> outputs zero immediately (asynchronously). After release all contexts are at I: first results code 10, ptr restarts at 0.

Source files
------------

// File: rtl/fsm_context_scheduler_if.sv
// Requester-side and result-side signals of the shared symbol-tracking scheduler.
interface fsm_context_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_bit;
  logic [NREQ-1:0] ctx_clear;
  logic [NREQ-1:0] req_ready;
  logic            busy;
  logic            out_valid;
  logic [IDW-1:0]  out_id;
  logic [1:0]      out_code;

  modport master (
    output req_valid, req_bit, ctx_clear,
    input  req_ready, busy, out_valid, out_id, out_code
  );

  modport slave (
    input  req_valid, req_bit, ctx_clear,
    output req_ready, busy, out_valid, out_id, out_code
  );
endinterface

// File: rtl/fsm_context_scheduler.sv
// One shared I/S/T tracking FSM time-multiplexed over NREQ requesters, each holding
// its own 2-bit context; round-robin grants with a per-grant burst limit.
module fsm_context_scheduler #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int BURST = 4
) (
  input logic                    clk,
  input logic                    reset,
  fsm_context_scheduler_if.slave bus
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} arb_state_t;

  localparam logic [1:0]     CTX_I   = 2'd0;
  localparam logic [1:0]     CTX_S   = 2'd1;
  localparam logic [1:0]     CTX_T   = 2'd2;
  localparam logic [3:0]     BURST_W = 4'(BURST);
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  function automatic logic [1:0] next_ctx_f(input logic [1:0] cur, input logic in_bit);
    case (cur)
      CTX_I:   next_ctx_f = CTX_S;
      CTX_S:   next_ctx_f = in_bit ? CTX_T : CTX_S;
      CTX_T:   next_ctx_f = in_bit ? CTX_S : CTX_T;
      default: next_ctx_f = CTX_I;
    endcase
  endfunction

  function automatic logic [1:0] code_f(input logic [1:0] ctx);
    case (ctx)
      CTX_I:   code_f = 2'b01;
      CTX_S:   code_f = 2'b10;
      CTX_T:   code_f = 2'b11;
      default: code_f = 2'b00;
    endcase
  endfunction

  arb_state_t      state_r, state_s;
  logic [IDW-1:0]  ptr_r, ptr_s;
  logic [IDW-1:0]  owner_r, owner_s;
  logic [3:0]      burst_cnt_r, burst_cnt_s;
  logic [1:0]      ctx_r [NREQ];
  logic            out_valid_r;
  logic [IDW-1:0]  out_id_r;
  logic [1:0]      out_code_r;

  logic            found_s;
  logic [IDW-1:0]  pick_s;
  logic [IDW:0]    idx_s;
  logic [IDW-1:0]  owner_inc_s;
  logic            consume_s;
  logic [NREQ-1:0] ready_s;
  logic [1:0]      new_ctx_s;
  logic [1:0]      code_s;

  // Round-robin pick: first valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found_s = 1'b0;
    pick_s  = ptr_r;
    idx_s   = {1'b0, ptr_r};
    for (int k = 0; k < NREQ; k++) begin
      idx_s = {1'b0, ptr_r} + (IDW+1)'(k);
      if (idx_s >= NREQ_W) begin
        idx_s = idx_s - NREQ_W;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && bus.req_valid[idx_s[IDW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = idx_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbiter next-state, burst accounting and consume strobe.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    owner_s     = owner_r;
    burst_cnt_s = burst_cnt_r;
    consume_s   = 1'b0;
    ready_s     = {NREQ{1'b0}};
    owner_inc_s = (owner_r == LAST_ID) ? {IDW{1'b0}} : owner_r + IDW'(1);
    case (state_r)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          owner_s     = pick_s;
          burst_cnt_s = 4'd0;
          state_s     = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (bus.req_valid[owner_r]) begin
          consume_s        = 1'b1;
          ready_s[owner_r] = 1'b1;
          burst_cnt_s      = burst_cnt_r + 4'd1;
          if (burst_cnt_s == BURST_W) begin
            state_s = ST_IDLE;
            ptr_s   = owner_inc_s;
          end else begin
            state_s = ST_GRANT;
          end
        end else begin
          state_s = ST_IDLE;
          ptr_s   = owner_inc_s;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // A clear on the owner in its consuming cycle overrides the computed state.
  always_comb begin
    new_ctx_s = next_ctx_f(ctx_r[owner_r], bus.req_bit[owner_r]);
    if (bus.ctx_clear[owner_r]) begin
      code_s = code_f(CTX_I);
    end else begin
      code_s = code_f(new_ctx_s);
    end
  end

  // Arbiter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {IDW{1'b0}};
      owner_r     <= {IDW{1'b0}};
      burst_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      owner_r     <= owner_s;
      burst_cnt_r <= burst_cnt_s;
    end
  end

  // Per-requester saved contexts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) ctx_r[i] <= CTX_I;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ctx_clear[i]) begin
          ctx_r[i] <= CTX_I;
        end else if (consume_s && (owner_r == IDW'(i))) begin
          ctx_r[i] <= new_ctx_s;
        end else begin
          ctx_r[i] <= ctx_r[i];
        end
      end
    end
  end

  // Result registers; id/code hold between results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_id_r    <= {IDW{1'b0}};
      out_code_r  <= 2'b00;
    end else begin
      out_valid_r <= consume_s;
      if (consume_s) begin
        out_id_r   <= owner_r;
        out_code_r <= code_s;
      end else begin
        out_id_r   <= out_id_r;
        out_code_r <= out_code_r;
      end
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.busy      = (state_r == ST_GRANT);
  assign bus.out_valid = out_valid_r;
  assign bus.out_id    = out_id_r;
  assign bus.out_code  = out_code_r;

endmodule

// File: tb/tb_fsm_context_scheduler.sv
// Directed bench for fsm_context_scheduler (NREQ=4, BURST=4) with hand-computed results.
module tb_fsm_context_scheduler;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  fsm_context_scheduler_if #(.NREQ(4), .IDW(2)) bus ();

  fsm_context_scheduler #(.NREQ(4), .IDW(2), .BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, check the combinational handshake, then the result after the edge.
  task automatic step(input string tag, input logic [3:0] v, input logic [3:0] b,
                      input logic [3:0] clr, input logic [3:0] e_rdy, input logic e_busy,
                      input logic e_ov, input logic [1:0] e_id, input logic [1:0] e_code);
    bus.req_valid = v;
    bus.req_bit   = b;
    bus.ctx_clear = clr;
    #1;
    chk({tag, ".rdy"},  8'(bus.req_ready), 8'(e_rdy));
    chk({tag, ".busy"}, 8'(bus.busy),      8'(e_busy));
    tick();
    chk({tag, ".ov"},   8'(bus.out_valid), 8'(e_ov));
    if (e_ov) begin
      chk({tag, ".id"},   8'(bus.out_id),   8'(e_id));
      chk({tag, ".code"}, 8'(bus.out_code), 8'(e_code));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".rdy"},  8'(bus.req_ready), 8'h00);
    chk({tag, ".busy"}, 8'(bus.busy),      8'h00);
    chk({tag, ".ov"},   8'(bus.out_valid), 8'h00);
    chk({tag, ".id"},   8'(bus.out_id),    8'h00);
    chk({tag, ".code"}, 8'(bus.out_code),  8'h00);
  endtask

  task automatic do_reset();
    bus.req_valid = 4'b0000;
    bus.req_bit   = 4'b0000;
    bus.ctx_clear = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_bit   = 4'b0000;
    bus.ctx_clear = 4'b0000;
    #1 reset = 1'b1;

    // 1: outputs quiet while reset is held with all requests valid
    tick();
    tick();
    check_zero("t1.rst");
    reset = 1'b0;
    step("t1.arb",  4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t1.own0", 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b10);

    // 2: single requester, bits 1,1,0,1 then burst end and wrap re-grant
    do_reset();
    step("t2.arb",  4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t2.s1",   4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b10);
    step("t2.s2",   4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b11);
    step("t2.s3",   4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b11);
    step("t2.s4",   4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b10);
    step("t2.idle", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t2.wrap", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b10);
    step("t2.rel",  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00);

    // 3: req 0 and 2 alternate bursts (ptr=1 so req 2 first); contexts independent
    step("t3.arb2", 4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t3.a1",   4'b0101, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 2'b10);
    step("t3.a2",   4'b0101, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 2'b11);
    step("t3.a3",   4'b0101, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 2'b10);
    step("t3.a4",   4'b0101, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 2'b11);
    step("t3.arb0", 4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t3.b1",   4'b0101, 4'b0100, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b10);
    step("t3.b2",   4'b0101, 4'b0100, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b10);
    step("t3.b3",   4'b0101, 4'b0100, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b10);
    step("t3.b4",   4'b0101, 4'b0100, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b10);
    step("t3.arb2b",4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t3.c1",   4'b0101, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 2'b10);
    step("t3.rel",  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00);

    // 4: req 1 reaches T, drops valid mid-grant, later resumes from T
    step("t4.arb",  4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t4.s1",   4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1, 2'b10);
    step("t4.s2",   4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1, 2'b11);
    step("t4.drop", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00);
    step("t4.idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t4.arb2", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t4.hold", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1, 2'b11);
    step("t4.rel",  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00);

    // 5: clear coincident with consumption from S; non-owner clear of ctx 0
    step("t5.arb",  4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t5.s1",   4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b1, 2'd3, 2'b10);
    step("t5.clr",  4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 2'b01);
    step("t5.aft",  4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b1, 2'd3, 2'b10);
    step("t5.s4",   4'b1000, 4'b0000, 4'b0001, 4'b1000, 1'b1, 1'b1, 2'd3, 2'b10);
    step("t5.idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t5.arb0", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t5.ctx0", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b10);
    step("t5.rel",  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00);

    // 6: asynchronous reset on the 2nd cycle of a burst
    step("t6.arb",  4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t6.s1",   4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 2'b11);
    reset = 1'b1;
    #1;
    check_zero("t6.async");
    tick();
    check_zero("t6.held");
    reset = 1'b0;
    step("t6.arb0", 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t6.c0",   4'b0101, 4'b0101, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 2'b10);
    step("t6.rel",  4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'b00);
    step("t6.arb2", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'b00);
    step("t6.c2",   4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
